// File: rtl/alu_dispatch.sv
// alu_dispatch: 8x32 operand register file and single-issue dispatcher feeding a 32-bit ALU.
// Defining ALU_DISPATCH_FLAGS_EN adds the registered flag_zero / flag_hi result flags.
module alu_dispatch #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [23:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_r,
    output logic [3:0]  alu_opcode,
    input  logic [63:0] alu_out,
    output logic        done,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data
`ifdef ALU_DISPATCH_FLAGS_EN
    ,
    output logic        flag_zero,
    output logic        flag_hi
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam logic [2:0] LAT = ALU_LATENCY[2:0];

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_rd;
    logic        r_wide;
    logic [31:0] r_regs [8];

    logic        w_accept;
    logic        w_wb;
    logic        w_host_wr;
    logic [2:0]  w_rs1;
    logic [2:0]  w_rs2;
    logic [2:0]  w_rd_hi;
    logic [31:0] w_src_a;
    logic [31:0] w_src_b;
    logic        w_unused;

    assign w_rs1    = instr[16:14];
    assign w_rs2    = instr[13:11];
    assign w_rd_hi  = r_rd + 3'd1;
    assign w_unused = ^instr[4:0];

    // A host write on the accept edge must be visible to the operands read on that edge.
    assign w_src_a = (w_host_wr && (wr_addr == w_rs1)) ? wr_data : r_regs[w_rs1];
    assign w_src_b = (w_host_wr && (wr_addr == w_rs2)) ? wr_data : r_regs[w_rs2];

    assign instr_ready = (r_state == S_IDLE);
    assign rd_data     = r_regs[rd_addr];

    // Next-state and per-edge control decode.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_wb         = 1'b0;
        w_host_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_host_wr = wr_en;
                if (instr_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                if (r_cnt == LAT) begin
                    w_wb         = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= 3'd0;
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Operand file: host writes in IDLE, ALU writeback (optionally two words) in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_host_wr) begin
            r_regs[wr_addr] <= wr_data;
        end else if (w_wb) begin
            r_regs[r_rd] <= alu_out[31:0];
            if (r_wide) begin
                r_regs[w_rd_hi] <= alu_out[63:32];
            end
        end
    end

    // Registered ALU operands, destination latch and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_r      <= 5'd0;
            alu_opcode <= 4'd0;
            r_rd       <= 3'd0;
            r_wide     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= w_wb;
            if (w_accept) begin
                alu_a      <= w_src_a;
                alu_b      <= w_src_b;
                alu_r      <= instr[10:6];
                alu_opcode <= instr[23:20];
                r_rd       <= instr[19:17];
                r_wide     <= instr[5];
            end
        end
    end

`ifdef ALU_DISPATCH_FLAGS_EN
    // Result flags track the most recent writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_zero <= 1'b0;
            flag_hi   <= 1'b0;
        end else if (w_wb) begin
            flag_zero <= (alu_out == 64'd0);
            flag_hi   <= (alu_out[63:32] != 32'd0);
        end
    end
`endif

endmodule
